// File: rtl/mod_const_mac_serial_if.sv
// Operand/result handshake bundle for the bit-serial modular constant multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface mod_const_mac_serial_if #(
    parameter int unsigned W = 6
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         acc_en;
    logic         clr_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;

    modport master (
        output in_valid, x, acc_en, clr_acc, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, acc_en, clr_acc, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/mod_const_mac_serial.sv
// Bit-serial z = (x*C) mod M, optionally folded into a modular accumulator.
// Horner evaluation, MSB first, one operand bit per clock.
module mod_const_mac_serial #(
    parameter int unsigned M = 47,
    parameter int unsigned W = 6,
    parameter int unsigned C = 63
) (
    input  logic                        clk,
    input  logic                        rst,
    mod_const_mac_serial_if.slave       bus
);
    localparam int unsigned IDX_W  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CR_INT = C % M;
    localparam logic [W-1:0] CR    = CR_INT[W-1:0];
    localparam logic [W:0]   MW    = M[W:0];

    if (M < 2 || W < $clog2(M)) begin : g_bad_params
        $error("mod_const_mac_serial: need M >= 2 and W >= clog2(M)");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ACC,
        DONE
    } state_e;

    state_e           state_q;
    logic [W-1:0]     x_q;
    logic             acc_en_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     r_q;
    logic [W-1:0]     acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [W-1:0]     z_q;

    logic [W:0]       dbl;
    logic [W:0]       sum;
    logic [W:0]       tot;
    logic [W-1:0]     r_d;
    logic [W-1:0]     acc_d;

    // All operands are < M, so each W+1-bit sum is < 2M and one subtract reduces it.
    always_comb begin
        dbl = {r_q, 1'b0};
        if (dbl >= MW) dbl = dbl - MW;
        sum = dbl + (x_q[idx_q] ? {1'b0, CR} : '0);
        if (sum >= MW) sum = sum - MW;
        r_d = sum[W-1:0];

        tot = {1'b0, acc_q} + {1'b0, r_q};
        if (tot >= MW) tot = tot - MW;
        acc_d = bus.clr_acc ? r_q : tot[W-1:0];
    end

    // NOTE: every register here uses <= so all updates see pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            acc_en_q    <= 1'b0;
            idx_q       <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
        end else begin
            // Outside ACC a clr_acc pulse just zeroes the accumulator.
            if (bus.clr_acc && state_q != ACC) acc_q <= '0;

            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.x;
                        acc_en_q   <= bus.acc_en;
                        r_q        <= '0;
                        idx_q      <= IDX_W'(W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    r_q <= r_d;
                    if (idx_q == '0) begin
                        if (acc_en_q) begin
                            state_q <= ACC;
                        end else begin
                            z_q         <= r_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                ACC: begin
                    acc_q       <= acc_d;
                    z_q         <= acc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
endmodule

// File: tb/tb_mod_const_mac_serial.sv
// Directed and sweep bench for mod_const_mac_serial with a result scoreboard.
// Two instances: default (M=47, W=6, C=63) and a wider one (M=251, W=8, C=1000).
module tb_mod_const_mac_serial;
    localparam int MA = 47,  WA = 6, CA = 63;
    localparam int MB = 251, WB = 8, CB = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_const_mac_serial_if #(.W(WA)) bus_a ();
    mod_const_mac_serial_if #(.W(WB)) bus_b ();

    mod_const_mac_serial #(.M(MA), .W(WA), .C(CA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mod_const_mac_serial #(.M(MB), .W(WB), .C(CB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          acc_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand to instance A and push the mathematically expected result.
    task automatic send_a(input int xv, input bit ae, input bit clr_in_acc);
        int n = 0;
        int p;
        while (bus_a.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("a_ready_before_send", 32'(bus_a.in_ready), 32'd1);
        bus_a.x        = WA'(xv);
        bus_a.acc_en   = ae;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.acc_en   = 1'b0;
        p = (xv * CA) % MA;
        if (ae) begin
            acc_model = clr_in_acc ? p : (acc_model + p) % MA;
            exp_a.push_back(32'(acc_model));
        end else begin
            exp_a.push_back(32'(p));
        end
    endtask

    // Wait for the result, check latency and value, optionally stall the consumer.
    task automatic collect_a(input int lat, input int hold, input bit clr_in_acc, input bit poke);
        int          n = 0;
        logic [31:0] zh;
        while (bus_a.out_valid !== 1'b1 && n < lat + 20) begin
            check("a_busy_in_ready", 32'(bus_a.in_ready), 32'd0);
            if (clr_in_acc && n == lat - 1) bus_a.clr_acc = 1'b1;
            tick();
            n++;
            bus_a.clr_acc = 1'b0;
        end
        check("a_latency", 32'(n), 32'(lat));
        if (exp_a.size() == 0) check("a_scoreboard_empty", 32'd1, 32'd0);
        else check("a_z", 32'(bus_a.z), exp_a.pop_front());
        zh = 32'(bus_a.z);
        if (hold > 0) begin
            bus_a.out_ready = 1'b0;
            if (poke) begin
                bus_a.x        = WA'(5);
                bus_a.in_valid = 1'b1;
            end
            repeat (hold) begin
                tick();
                check("a_hold_z", 32'(bus_a.z), zh);
                check("a_hold_valid", 32'(bus_a.out_valid), 32'd1);
                check("a_hold_in_ready", 32'(bus_a.in_ready), 32'd0);
            end
            bus_a.in_valid  = 1'b0;
            bus_a.out_ready = 1'b1;
        end
        tick();
        check("a_valid_dropped", 32'(bus_a.out_valid), 32'd0);
        check("a_ready_returned", 32'(bus_a.in_ready), 32'd1);
    endtask

    task automatic send_b(input int xv);
        int n = 0;
        while (bus_b.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("b_ready_before_send", 32'(bus_b.in_ready), 32'd1);
        bus_b.x        = WB'(xv);
        bus_b.in_valid = 1'b1;
        tick();
        bus_b.in_valid = 1'b0;
        exp_b.push_back(32'((longint'(xv) * CB) % MB));
    endtask

    task automatic collect_b(input int hold);
        int n = 0;
        while (bus_b.out_valid !== 1'b1 && n < WB + 20) begin
            tick();
            n++;
        end
        check("b_latency", 32'(n), 32'(WB));
        if (exp_b.size() == 0) check("b_scoreboard_empty", 32'd1, 32'd0);
        else check("b_z", 32'(bus_b.z), exp_b.pop_front());
        bus_b.out_ready = 1'b0;
        repeat (hold) tick();
        bus_b.out_ready = 1'b1;
        tick();
        check("b_valid_dropped", 32'(bus_b.out_valid), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.x         = '0;
        bus_a.acc_en    = 1'b0;
        bus_a.clr_acc   = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.x         = '0;
        bus_b.acc_en    = 1'b0;
        bus_b.clr_acc   = 1'b0;
        bus_b.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("reset_a_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("reset_a_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("reset_a_z", 32'(bus_a.z), 32'd0);
        check("reset_b_in_ready", 32'(bus_b.in_ready), 32'd1);
        check("reset_b_out_valid", 32'(bus_b.out_valid), 32'd0);

        // Plain multiply: 1->16, 3->1, 63->21, 0->0.
        send_a(1,  1'b0, 1'b0); collect_a(WA, 0, 1'b0, 1'b0);
        send_a(3,  1'b0, 1'b0); collect_a(WA, 0, 1'b0, 1'b0);
        send_a(63, 1'b0, 1'b0); collect_a(WA, 0, 1'b0, 1'b0);
        send_a(0,  1'b0, 1'b0); collect_a(WA, 0, 1'b0, 1'b0);

        // Accumulate: clear in IDLE, then 16, 17, 38, 38.
        bus_a.clr_acc = 1'b1;
        tick();
        bus_a.clr_acc = 1'b0;
        acc_model = 0;
        send_a(1,  1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);
        send_a(3,  1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);
        send_a(63, 1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);
        send_a(47, 1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);

        // clr_acc during ACC loads r directly (21), then 21+16 = 37.
        send_a(63, 1'b1, 1'b1); collect_a(WA + 1, 0, 1'b1, 1'b0);
        send_a(1,  1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);

        // Backpressure with an ignored operand offered, then x=5 -> 33.
        send_a(3, 1'b0, 1'b0); collect_a(WA, 5, 1'b0, 1'b1);
        send_a(5, 1'b0, 1'b0); collect_a(WA, 0, 1'b0, 1'b0);

        // Reset on the third RUN edge abandons the transaction and clears acc.
        bus_a.x        = WA'(9);
        bus_a.acc_en   = 1'b1;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.acc_en   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_model = 0;
        check("rst_run_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("rst_run_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_run_z", 32'(bus_a.z), 32'd0);
        repeat (12) begin
            check("rst_no_stale_output", 32'(bus_a.out_valid), 32'd0);
            tick();
        end
        send_a(3, 1'b1, 1'b0); collect_a(WA + 1, 0, 1'b0, 1'b0);

        // Full operand sweeps with random idle gaps and consumer stalls.
        for (int i = 0; i < (1 << WA); i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_a(i, 1'b0, 1'b0);
            collect_a(WA, $urandom_range(0, 2), 1'b0, 1'b0);
        end
        for (int i = 0; i < (1 << WB); i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_b(i);
            collect_b($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
